// File: rtl/shape_spring_engine.sv
// Shape-restoring spring-damper solver: one node force per handshake,
// negated force sum reported as the axle reaction after each solve.
//
// Ports:
//   clk_in, rst_in            clock, async active-high reset
//   start_in                  begin a solve (ignored while busy_out)
//   k_in, b_in                per-axis unsigned stiffness/damping [0]=x [1]=y
//   nodes, ideal_nodes        signed positions [axis][node]
//   velocities, axle_velocity signed velocities
//   force_*_out, force_ready_in   per-node force stream (valid/ready)
//   axle_force_x/y            saturated negated force sum
//   busy_out, done_out        solve in progress / final-result pulse
module shape_spring_engine #(
  parameter int NUM_NODES     = 10,
  parameter int CONSTANT_SIZE = 4,
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter int FORCE_SIZE    = 8,
  parameter int FRAC_BITS     = 0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic start_in,
  input  logic [1:0][CONSTANT_SIZE-1:0] k_in,
  input  logic [1:0][CONSTANT_SIZE-1:0] b_in,
  input  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] nodes,
  input  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] ideal_nodes,
  input  logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] velocities,
  input  logic [1:0][VELOCITY_SIZE-1:0] axle_velocity,
  output logic signed [FORCE_SIZE-1:0] force_x_out,
  output logic signed [FORCE_SIZE-1:0] force_y_out,
  output logic [$clog2(NUM_NODES):0] force_idx_out,
  output logic force_valid_out,
  input  logic force_ready_in,
  output logic signed [FORCE_SIZE-1:0] axle_force_x,
  output logic signed [FORCE_SIZE-1:0] axle_force_y,
  output logic busy_out,
  output logic done_out
);

  localparam int IW = $clog2(NUM_NODES) + 1;
  localparam int SW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int AW = FORCE_SIZE + IW;
  localparam int DW = POSITION_SIZE + 1;
  localparam int VW = VELOCITY_SIZE + 1;
  localparam int KW = CONSTANT_SIZE + 1 + DW;
  localparam int BW = CONSTANT_SIZE + 1 + VW;
  localparam int RW = ((KW > BW) ? KW : BW) + 1;

  localparam logic signed [RW-1:0] RMAX = RW'((1 << (FORCE_SIZE-1)) - 1);
  localparam logic signed [RW-1:0] RMIN = ~RMAX;
  localparam logic signed [AW-1:0] AMAX = AW'((1 << (FORCE_SIZE-1)) - 1);
  localparam logic signed [AW-1:0] AMIN = ~AMAX;

  localparam logic [FORCE_SIZE-1:0] FPOS = {1'b0, {(FORCE_SIZE-1){1'b1}}};
  localparam logic [FORCE_SIZE-1:0] FNEG = {1'b1, {(FORCE_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_EMIT, S_DONE} state_t;

  function automatic logic signed [FORCE_SIZE-1:0] spring(
    input logic [CONSTANT_SIZE-1:0] k,
    input logic [CONSTANT_SIZE-1:0] b,
    input logic signed [POSITION_SIZE-1:0] pos,
    input logic signed [POSITION_SIZE-1:0] ideal,
    input logic signed [VELOCITY_SIZE-1:0] vel,
    input logic signed [VELOCITY_SIZE-1:0] av
  );
    logic signed [DW-1:0] d;
    logic signed [VW-1:0] rv;
    logic signed [KW-1:0] kd;
    logic signed [BW-1:0] bv;
    logic signed [RW-1:0] raw;
    d   = DW'(ideal) - DW'(pos);
    rv  = VW'(vel) - VW'(av);
    kd  = $signed({1'b0, k}) * d;
    bv  = $signed({1'b0, b}) * rv;
    raw = (RW'(kd) - RW'(bv)) >>> FRAC_BITS;
    if (raw > RMAX) return FPOS;
    if (raw < RMIN) return FNEG;
    return raw[FORCE_SIZE-1:0];
  endfunction

  function automatic logic signed [FORCE_SIZE-1:0] sat_acc(
    input logic signed [AW-1:0] v
  );
    if (v > AMAX) return FPOS;
    if (v < AMIN) return FNEG;
    return v[FORCE_SIZE-1:0];
  endfunction

  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0][CONSTANT_SIZE-1:0] k_q, k_d, b_q, b_d;
  logic [1:0][VELOCITY_SIZE-1:0] av_q, av_d;
  logic signed [FORCE_SIZE-1:0] fx_q, fx_d, fy_q, fy_d;
  logic [IW-1:0] fidx_q, fidx_d;
  logic fvalid_q, fvalid_d;
  logic signed [AW-1:0] accx_q, accx_d, accy_q, accy_d;
  logic signed [AW-1:0] accx_nx, accy_nx;
  logic signed [FORCE_SIZE-1:0] axx_q, axx_d, axy_q, axy_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [SW-1:0] sel;

  assign sel     = SW'(idx_q);
  assign accx_nx = accx_q - AW'(fx_q);
  assign accy_nx = accy_q - AW'(fy_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    k_d      = k_q;
    b_d      = b_q;
    av_d     = av_q;
    fx_d     = fx_q;
    fy_d     = fy_q;
    fidx_d   = fidx_q;
    fvalid_d = fvalid_q;
    accx_d   = accx_q;
    accy_d   = accy_q;
    axx_d    = axx_q;
    axy_d    = axy_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          k_d     = k_in;
          b_d     = b_in;
          av_d    = axle_velocity;
          accx_d  = '0;
          accy_d  = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        fx_d = spring(k_q[0], b_q[0], nodes[0][sel],
                      ideal_nodes[0][sel], velocities[0][sel], av_q[0]);
        fy_d = spring(k_q[1], b_q[1], nodes[1][sel],
                      ideal_nodes[1][sel], velocities[1][sel], av_q[1]);
        fidx_d   = idx_q;
        fvalid_d = 1'b1;
        state_d  = S_EMIT;
      end
      S_EMIT: begin
        if (fvalid_q && force_ready_in) begin
          fvalid_d = 1'b0;
          accx_d   = accx_nx;
          accy_d   = accy_nx;
          if (idx_q == IW'(NUM_NODES - 1)) begin
            // Publish on entry so the result is final while done_out is high.
            axx_d   = sat_acc(accx_nx);
            axy_d   = sat_acc(accy_nx);
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_CALC;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      k_q      <= '0;
      b_q      <= '0;
      av_q     <= '0;
      fx_q     <= '0;
      fy_q     <= '0;
      fidx_q   <= '0;
      fvalid_q <= 1'b0;
      accx_q   <= '0;
      accy_q   <= '0;
      axx_q    <= '0;
      axy_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      k_q      <= k_d;
      b_q      <= b_d;
      av_q     <= av_d;
      fx_q     <= fx_d;
      fy_q     <= fy_d;
      fidx_q   <= fidx_d;
      fvalid_q <= fvalid_d;
      accx_q   <= accx_d;
      accy_q   <= accy_d;
      axx_q    <= axx_d;
      axy_q    <= axy_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign force_x_out     = fx_q;
  assign force_y_out     = fy_q;
  assign force_idx_out   = fidx_q;
  assign force_valid_out = fvalid_q;
  assign axle_force_x    = axx_q;
  assign axle_force_y    = axy_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;

endmodule

// File: tb/tb_shape_spring_engine.sv
// Randomized + directed bench for shape_spring_engine against a
// behavioural model of node forces, stream timing and axle result.
module tb_shape_spring_engine;

  localparam int N  = 10;
  localparam int IW = $clog2(N) + 1;

  logic clk = 0;
  logic rst_in = 1;
  logic start_in = 0;
  logic [1:0][3:0] k_in = '0;
  logic [1:0][3:0] b_in = '0;
  logic [1:0][N-1:0][7:0] nodes = '0;
  logic [1:0][N-1:0][7:0] ideal_nodes = '0;
  logic [1:0][N-1:0][7:0] velocities = '0;
  logic [1:0][7:0] axle_velocity = '0;
  logic signed [7:0] force_x_out, force_y_out;
  logic [IW-1:0] force_idx_out;
  logic force_valid_out;
  logic force_ready_in = 1;
  logic signed [7:0] axle_force_x, axle_force_y;
  logic busy_out, done_out;

  logic start1 = 0;
  logic [1:0][3:0] k1 = '0;
  logic [1:0][3:0] b1 = '0;
  logic [1:0][0:0][7:0] nodes1 = '0;
  logic [1:0][0:0][7:0] ideal1 = '0;
  logic [1:0][0:0][7:0] vel1 = '0;
  logic [1:0][7:0] av1 = '0;
  logic signed [7:0] fx1, fy1, ax1, ay1;
  logic [0:0] fidx1;
  logic fvalid1, busy1, done1;
  logic ready1 = 1;

  shape_spring_engine dut (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
    .k_in(k_in), .b_in(b_in), .nodes(nodes),
    .ideal_nodes(ideal_nodes), .velocities(velocities),
    .axle_velocity(axle_velocity),
    .force_x_out(force_x_out), .force_y_out(force_y_out),
    .force_idx_out(force_idx_out),
    .force_valid_out(force_valid_out),
    .force_ready_in(force_ready_in),
    .axle_force_x(axle_force_x), .axle_force_y(axle_force_y),
    .busy_out(busy_out), .done_out(done_out)
  );

  shape_spring_engine #(.NUM_NODES(1), .FRAC_BITS(2)) dut1 (
    .clk_in(clk), .rst_in(rst_in), .start_in(start1),
    .k_in(k1), .b_in(b1), .nodes(nodes1),
    .ideal_nodes(ideal1), .velocities(vel1),
    .axle_velocity(av1),
    .force_x_out(fx1), .force_y_out(fy1),
    .force_idx_out(fidx1),
    .force_valid_out(fvalid1),
    .force_ready_in(ready1),
    .axle_force_x(ax1), .axle_force_y(ay1),
    .busy_out(busy1), .done_out(done1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int clip(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int mforce(input int k, input int b, input int p,
                                input int i, input int v, input int av,
                                input int fr);
    return clip((k * (i - p) - b * (v - av)) >>> fr);
  endfunction

  // Model of one solve: forces computed up front from the latched inputs.
  bit in_solve = 0;
  bit was_solving;
  bit exp_valid;
  int efx[N];
  int efy[N];
  int nidx = 0;
  int next_valid_cyc = 0;
  int done_cyc = -1;
  int start_cyc = -1;
  int done_seen = -1;
  int pend_ax = 0, pend_ay = 0;
  int exp_ax = 0, exp_ay = 0;

  always @(negedge clk) begin
    if (rst_in) begin
      in_solve = 0;
      exp_ax   = 0;
      exp_ay   = 0;
      done_cyc = -1;
    end else begin
      if (cyc == done_cyc) begin
        exp_ax = pend_ax;
        exp_ay = pend_ay;
      end
      exp_valid = in_solve && nidx < N && cyc >= next_valid_cyc;
      chk("busy", busy_out, in_solve);
      chk("done", done_out, cyc == done_cyc);
      chk("valid", force_valid_out, exp_valid);
      if (done_out) done_seen = cyc;
      if (!in_solve || cyc == done_cyc) begin
        chk("axle_x", axle_force_x, exp_ax);
        chk("axle_y", axle_force_y, exp_ay);
      end
      if (exp_valid) begin
        chk("fx", force_x_out, efx[nidx]);
        chk("fy", force_y_out, efy[nidx]);
        chk("fidx", force_idx_out, nidx);
        if (force_ready_in) begin
          nidx++;
          next_valid_cyc = cyc + 2;
          if (nidx == N) done_cyc = cyc + 1;
        end
      end
      was_solving = in_solve;
      if (cyc == done_cyc) in_solve = 0;
      if (!was_solving && start_in) begin
        int sx, sy;
        sx = 0;
        sy = 0;
        for (int i = 0; i < N; i++) begin
          efx[i] = mforce(k_in[0], b_in[0], $signed(nodes[0][i]),
                          $signed(ideal_nodes[0][i]),
                          $signed(velocities[0][i]),
                          $signed(axle_velocity[0]), 0);
          efy[i] = mforce(k_in[1], b_in[1], $signed(nodes[1][i]),
                          $signed(ideal_nodes[1][i]),
                          $signed(velocities[1][i]),
                          $signed(axle_velocity[1]), 0);
          sx += efx[i];
          sy += efy[i];
        end
        pend_ax = clip(-sx);
        pend_ay = clip(-sy);
        in_solve = 1;
        nidx = 0;
        start_cyc = cyc;
        next_valid_cyc = cyc + 2;
        done_cyc = -1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic uniform(input int px, input int py, input int ix,
                         input int iy, input int vx, input int vy);
    for (int i = 0; i < N; i++) begin
      nodes[0][i]       = 8'(px);
      nodes[1][i]       = 8'(py);
      ideal_nodes[0][i] = 8'(ix);
      ideal_nodes[1][i] = 8'(iy);
      velocities[0][i]  = 8'(vx);
      velocities[1][i]  = 8'(vy);
    end
  endtask

  // rmode: 0 ready high, 1 random ready + stray starts, 2 stall node 3
  task automatic run_solve(input int rmode, input bit start_at_done,
                           output int lat);
    int stall;
    bit got;
    stall = 0;
    got = 0;
    force_ready_in = 1;
    start_in = 1;
    step();
    start_in = 0;
    for (int t = 0; t < 400 && !got; t++) begin
      start_in = 0;
      if (done_out) begin
        got = 1;
        start_in = start_at_done;
      end else if (rmode == 1) begin
        force_ready_in = ($urandom_range(0, 3) != 0);
        start_in = ($urandom_range(0, 7) == 0);
      end else if (rmode == 2) begin
        if (force_valid_out && force_idx_out == 3 && stall < 5) begin
          force_ready_in = 0;
          stall++;
        end else begin
          force_ready_in = 1;
        end
      end
      step();
    end
    start_in = 0;
    force_ready_in = 1;
    if (!got) chk("done_timeout", 0, 1);
    lat = done_seen - start_cyc;
    step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_fx"}, force_x_out, 0);
    chk({tag, "_fy"}, force_y_out, 0);
    chk({tag, "_idx"}, force_idx_out, 0);
    chk({tag, "_valid"}, force_valid_out, 0);
    chk({tag, "_busy"}, busy_out, 0);
    chk({tag, "_done"}, done_out, 0);
    chk({tag, "_ax"}, axle_force_x, 0);
    chk({tag, "_ay"}, axle_force_y, 0);
  endtask

  initial begin
    int lat;
    bit found;
    repeat (3) step();
    chk_zero("reset");
    rst_in = 0;
    step();

    chk("model_basic", mforce(2, 1, 10, 12, 3, 1, 0), 2);
    chk("model_sat", mforce(15, 0, 0, 100, 0, 0, 0), 127);
    chk("model_frac_neg", mforce(3, 0, 0, -5, 0, 0, 2), -4);

    // Basic solve
    k_in = {4'd2, 4'd2};
    b_in = {4'd1, 4'd1};
    axle_velocity = {8'd0, 8'd1};
    uniform(10, 5, 12, 5, 3, 0);
    run_solve(0, 0, lat);
    chk("latency", lat, 21);
    chk("basic_ax", axle_force_x, -20);
    chk("basic_ay", axle_force_y, 0);

    // Backpressure on node 3 for 5 cycles
    run_solve(2, 0, lat);
    chk("bp_latency", lat, 26);

    // Per-node saturation
    k_in = {4'd15, 4'd15};
    b_in = '0;
    axle_velocity = '0;
    uniform(0, 0, 0, 0, 0, 0);
    ideal_nodes[0][0] = 8'd100;
    ideal_nodes[1][0] = 8'(-100);
    run_solve(0, 1, lat);
    chk("sat_ax", axle_force_x, -127);
    chk("sat_ay", axle_force_y, 127);

    // Accumulator clip
    k_in = {4'd0, 4'd15};
    uniform(0, 0, 100, 0, 0, 0);
    run_solve(0, 0, lat);
    chk("accclip_ax", axle_force_x, -128);
    chk("accclip_ay", axle_force_y, 0);

    // Randomized solves
    for (int r = 0; r < 8; r++) begin
      k_in = 8'($urandom);
      b_in = 8'($urandom);
      axle_velocity = 16'($urandom);
      for (int a = 0; a < 2; a++)
        for (int i = 0; i < N; i++) begin
          nodes[a][i]       = 8'($urandom);
          ideal_nodes[a][i] = 8'($urandom);
          velocities[a][i]  = 8'($urandom);
        end
      run_solve(1, r[0], lat);
    end

    // Fractional build, single node
    k1 = {4'd3, 4'd3};
    ideal1[0][0] = 8'd5;
    ideal1[1][0] = 8'(-5);
    start1 = 1;
    step();
    start1 = 0;
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      if (fvalid1) found = 1;
      else step();
    end
    chk("frac_valid", fvalid1, 1);
    chk("frac_fx", fx1, 3);
    chk("frac_fy", fy1, -4);
    chk("frac_idx", fidx1, 0);
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      if (done1) found = 1;
      else step();
    end
    chk("frac_done", done1, 1);
    chk("frac_ax", ax1, -3);
    chk("frac_ay", ay1, 4);
    step();

    // Reset during EMIT of node 4
    k_in = {4'd2, 4'd2};
    b_in = {4'd1, 4'd1};
    axle_velocity = {8'd0, 8'd1};
    uniform(10, 5, 12, 5, 3, 0);
    force_ready_in = 1;
    start_in = 1;
    step();
    start_in = 0;
    found = 0;
    for (int t = 0; t < 100 && !found; t++) begin
      if (force_valid_out && force_idx_out == 4) begin
        force_ready_in = 0;
        found = 1;
      end else begin
        step();
      end
    end
    chk("rst_reach_node4", found, 1);
    #1;
    rst_in = 1;
    #1;
    chk_zero("midrst");
    step();
    step();
    rst_in = 0;
    force_ready_in = 1;
    step();
    run_solve(0, 0, lat);
    chk("post_rst_latency", lat, 21);
    chk("post_rst_ax", axle_force_x, -20);
    chk("post_rst_ay", axle_force_y, 0);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
